// File: rtl/echo_request_deser.sv
// Packs WORDS inbound words into one message, holds it in a single-entry
// buffer and hands it downstream with ENA/RDY handshakes on both sides.
module echo_request_deser #(
  parameter int WORD_WIDTH  = 32,
  parameter int WORDS       = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          in_enq__ENA,
  input  logic [WORD_WIDTH-1:0]         in_enq_v,
  output logic                          in_enq__RDY,
  output logic                          pipe_enq__ENA,
  output logic [WORD_WIDTH*WORDS-1:0]   pipe_enq_v,
  input  logic                          pipe_enq__RDY,
  output logic [COUNT_WIDTH-1:0]        msg_count
);

  localparam int MSG_WIDTH = WORD_WIDTH * WORDS;
  localparam int CNT_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORDS - 1);

  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [MSG_WIDTH-1:0]   msg_buf_q, msg_buf_d;
  logic                   full_q, full_d;
  logic [COUNT_WIDTH-1:0] msg_count_q, msg_count_d;
  logic                   accept, deliver, complete;

  always_comb begin
    deliver     = full_q && pipe_enq__RDY;
    in_enq__RDY = !full_q || pipe_enq__RDY;
    accept      = in_enq__ENA && in_enq__RDY;
    complete    = 1'b0;
    cnt_d       = cnt_q;
    msg_buf_d   = msg_buf_q;
    msg_count_d = msg_count_q;

    // Word 0 of the next message may land while the held one is delivered;
    // downstream samples the pre-edge buffer, so the overwrite is safe.
    if (accept) begin
      msg_buf_d[int'(cnt_q) * WORD_WIDTH +: WORD_WIDTH] = in_enq_v;
      if (cnt_q == LAST_IDX) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    full_d = (full_q && !deliver) || complete;

    if (deliver) begin
      msg_count_d = msg_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q       <= '0;
      msg_buf_q   <= '0;
      full_q      <= 1'b0;
      msg_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      msg_buf_q   <= msg_buf_d;
      full_q      <= full_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign pipe_enq__ENA = deliver;
  assign pipe_enq_v    = msg_buf_q;
  assign msg_count     = msg_count_q;

endmodule
